// File: rtl/synth_pkg.sv
// Shared note/velocity types, allocator FSM states and pool defaults for the synth voice path.
package synth_pkg;

  localparam int DEFAULT_NUM_VOICES = 8;
  localparam int DEFAULT_AGE_W      = 8;

  typedef logic [6:0] note_t;
  typedef logic [6:0] vel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters: the committed voice restarts at zero and every
// other sounding voice grows one step older.
module voice_age_tracker #(
  parameter  int NUM_VOICES = 8,
  parameter  int AGE_W      = 8,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_commit,
  input  logic [IDX_W-1:0]                    i_target,
  input  logic [NUM_VOICES-1:0]               i_active,
  output logic [NUM_VOICES-1:0][AGE_W-1:0]    o_ages
);

  logic [NUM_VOICES-1:0][AGE_W-1:0] r_age;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_age <= '0;
    end else if (i_commit) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == i_target) begin
          r_age[i] <= '0;
        end else if (i_active[i] && (r_age[i] != {AGE_W{1'b1}})) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  assign o_ages = r_age;

endmodule

// File: rtl/voice_allocator.sv
// Assigns MIDI note events to a fixed voice pool: one scan cycle per voice, then a commit.
// Define VOICE_STEAL_EN to let a note-on steal the oldest gated voice instead of dropping.
module voice_allocator
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter  int AGE_W      = DEFAULT_AGE_W,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_evt_valid,
  output logic                    o_evt_ready,
  input  logic                    i_evt_note_on,
  input  logic [6:0]              i_evt_note,
  input  logic [6:0]              i_evt_vel,
  input  logic [NUM_VOICES-1:0]   i_voice_idle,
  output logic [NUM_VOICES-1:0]   o_gate,
  output logic [NUM_VOICES-1:0]   o_trig,
  output logic [7*NUM_VOICES-1:0] o_voice_note,
  output logic [7*NUM_VOICES-1:0] o_voice_vel,
  output logic                    o_drop
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t r_state;
  logic         r_ready;
  logic [IDX_W-1:0] r_idx;
  logic         r_on;
  note_t        r_note;
  vel_t         r_vel;

  logic             r_matchFound, r_freeFound, r_relFound;
  logic [IDX_W-1:0] r_matchIdx, r_freeIdx, r_relIdx;
  logic [AGE_W-1:0] r_relAge;
  logic [NUM_VOICES-1:0] r_offMask;
`ifdef VOICE_STEAL_EN
  logic             r_gatFound;
  logic [IDX_W-1:0] r_gatIdx;
  logic [AGE_W-1:0] r_gatAge;
`endif

  logic [NUM_VOICES-1:0]        r_gate, r_trig;
  logic                         r_drop;
  logic [NUM_VOICES-1:0][6:0]   r_voiceNote, r_voiceVel;

  logic [NUM_VOICES-1:0][AGE_W-1:0] w_ages;
  logic             w_scanGate, w_scanIdle, w_scanMatch;
  logic [AGE_W-1:0] w_scanAge;
  logic             w_noteOn, w_hasTarget, w_allocCommit;
  logic [IDX_W-1:0] w_target;
  logic [NUM_VOICES-1:0] w_active;

  assign w_scanGate  = r_gate[r_idx];
  assign w_scanIdle  = i_voice_idle[r_idx];
  assign w_scanAge   = w_ages[r_idx];
  assign w_scanMatch = (r_voiceNote[r_idx] == r_note);
  assign w_noteOn    = r_on && (r_vel != '0);
  assign w_active    = r_gate | ~i_voice_idle;

  // Preference order: held note, free voice, oldest released, oldest gated.
  always_comb begin
    w_hasTarget = 1'b1;
    w_target    = '0;
    if (r_matchFound) begin
      w_target = r_matchIdx;
    end else if (r_freeFound) begin
      w_target = r_freeIdx;
    end else if (r_relFound) begin
      w_target = r_relIdx;
`ifdef VOICE_STEAL_EN
    end else if (r_gatFound) begin
      w_target = r_gatIdx;
`endif
    end else begin
      w_hasTarget = 1'b0;
    end
  end

  assign w_allocCommit = (r_state == COMMIT) && w_noteOn && w_hasTarget;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_age (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_commit (w_allocCommit),
    .i_target (w_target),
    .i_active (w_active),
    .o_ages   (w_ages)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_idx        <= '0;
      r_on         <= 1'b0;
      r_note       <= '0;
      r_vel        <= '0;
      r_matchFound <= 1'b0;
      r_matchIdx   <= '0;
      r_freeFound  <= 1'b0;
      r_freeIdx    <= '0;
      r_relFound   <= 1'b0;
      r_relIdx     <= '0;
      r_relAge     <= '0;
      r_offMask    <= '0;
`ifdef VOICE_STEAL_EN
      r_gatFound   <= 1'b0;
      r_gatIdx     <= '0;
      r_gatAge     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (i_evt_valid && r_ready) begin
            r_state      <= SCAN;
            r_ready      <= 1'b0;
            r_idx        <= '0;
            r_on         <= i_evt_note_on;
            r_note       <= i_evt_note;
            r_vel        <= i_evt_vel;
            r_matchFound <= 1'b0;
            r_freeFound  <= 1'b0;
            r_relFound   <= 1'b0;
            r_offMask    <= '0;
`ifdef VOICE_STEAL_EN
            r_gatFound   <= 1'b0;
`endif
          end
        end
        SCAN: begin
          r_ready <= 1'b0;
          if (!r_matchFound && w_scanMatch && (w_scanGate || !w_scanIdle)) begin
            r_matchFound <= 1'b1;
            r_matchIdx   <= r_idx;
          end
          if (!r_freeFound && !w_scanGate && w_scanIdle) begin
            r_freeFound <= 1'b1;
            r_freeIdx   <= r_idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (!w_scanGate && !w_scanIdle && (!r_relFound || (w_scanAge > r_relAge))) begin
            r_relFound <= 1'b1;
            r_relIdx   <= r_idx;
            r_relAge   <= w_scanAge;
          end
`ifdef VOICE_STEAL_EN
          if (w_scanGate && (!r_gatFound || (w_scanAge > r_gatAge))) begin
            r_gatFound <= 1'b1;
            r_gatIdx   <= r_idx;
            r_gatAge   <= w_scanAge;
          end
`endif
          r_offMask[r_idx] <= w_scanGate && w_scanMatch;
          if (r_idx == LAST_IDX) begin
            r_state <= COMMIT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Note/velocity survive a note-off so the release tail keeps its pitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gate      <= '0;
      r_trig      <= '0;
      r_drop      <= 1'b0;
      r_voiceNote <= '0;
      r_voiceVel  <= '0;
    end else begin
      r_trig <= '0;
      r_drop <= 1'b0;
      if (r_state == COMMIT) begin
        if (w_noteOn) begin
          if (w_hasTarget) begin
            r_gate[w_target]      <= 1'b1;
            r_trig[w_target]      <= 1'b1;
            r_voiceNote[w_target] <= r_note;
            r_voiceVel[w_target]  <= r_vel;
          end else begin
            r_drop <= 1'b1;
          end
        end else begin
          r_gate <= r_gate & ~r_offMask;
        end
      end
    end
  end

  assign o_evt_ready  = r_ready;
  assign o_gate       = r_gate;
  assign o_trig       = r_trig;
  assign o_drop       = r_drop;
  assign o_voice_note = r_voiceNote;
  assign o_voice_vel  = r_voiceVel;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Schedules MIDI note events onto a fixed pool of synth voices. Sits between the keycode/MIDI event source (CPU-side PIO path) and the `synth` voice array, both clocked on `CLK`. Each accepted note-on is assigned to one voice, preferring in order:

- a voice already holding that note;
- a free voice;
- the oldest released voice;
- the oldest gated voice (steal).

It drives per-voice gate, trigger, note and velocity.

## Interface
- `NUM_VOICES`, 8, voice pool size (2..16)
- `AGE_W`, 8, width of per-voice saturating age counter
- `CLK` in 1 — system clock (main CPU clock domain)
- `RESET_N` in 1 — asynchronous, active-low reset
- `EVT_VALID` in 1 — event present
- `EVT_READY` out 1 — allocator can accept event
- `EVT_NOTE_ON` in 1 — 1 = note-on, 0 = note-off
- `EVT_NOTE` in 7 — MIDI note number
- `EVT_VEL` in 7 — MIDI velocity
- `VOICE_IDLE` in NUM_VOICES — per-voice envelope finished (from synth)
- `GATE` out NUM_VOICES — per-voice key held
- `TRIG` out NUM_VOICES — one-cycle envelope restart pulse
- `VOICE_NOTE` out 7*NUM_VOICES — voice i note at [7i+6:7i]
- `VOICE_VEL` out 7*NUM_VOICES — voice i velocity, same packing
- `DROP` out 1 — one-cycle pulse, note-on discarded

## Operation
- **FSM states:** IDLE, SCAN, COMMIT.
  - IDLE: `EVT_READY`=1. On `EVT_VALID` & `EVT_READY`, latch note, velocity and on/off, then go to SCAN.
  - SCAN: one voice per cycle, index 0..NUM_VOICES-1. Go to COMMIT after the last index.
  - COMMIT: apply the result, then go to IDLE.
- **Velocity 0:** a note-on with velocity 0 is treated as a note-off.
- **Scan classification** (voice i, sampled in its scan cycle):
  - match: `VOICE_NOTE[i]`==note and (`GATE[i]` or !`VOICE_IDLE[i]`)
  - free: !`GATE[i]` & `VOICE_IDLE[i]`
  - released: !`GATE[i]` & !`VOICE_IDLE[i]`
  - gated: `GATE[i]`
- **Candidate tracking:** keep the first match, the first free voice, the oldest released voice and the oldest gated voice.
  - Oldest means largest age.
  - Ties go to the lowest index (strict > compare).
- **Note-on commit:**
  - Target = match, else free, else released, else gated.
  - Set `GATE[t]`=1, pulse `TRIG[t]`=1, write `VOICE_NOTE`/`VOICE_VEL[t]`.
  - Set age[t]=0. Every other voice with `GATE` or !`VOICE_IDLE` increments its age, saturating at 2^AGE_W-1.
- **Note-off:**
  - During SCAN, record a bitmask of voices with `GATE`=1 and matching note.
  - In COMMIT, clear those `GATE` bits. No `TRIG`, no age change.
  - No match: no effect.
- Note and velocity registers hold their value after note-off, so release continues on the correct pitch.

## Timing
- **Reset values:** `GATE`=0, `TRIG`=0, `VOICE_NOTE`=0, `VOICE_VEL`=0, ages=0, `DROP`=0, state IDLE.
- `EVT_READY` is 0 while `RESET_N`=0 and 1 from the first clock after deassertion.
- **Latency:** accept edge → `GATE`/`TRIG`/`VOICE_*` visible NUM_VOICES+1 cycles later.
- **Throughput:** one event per NUM_VOICES+2 cycles. `EVT_READY`=0 during SCAN and COMMIT.
- `TRIG` is high for exactly one cycle, coincident with the `GATE` update.
- `EVT_VALID` may be held. A new event is accepted only in IDLE, and the inputs need to be stable only at the accept edge.
- `VOICE_IDLE` changing mid-scan is honoured only for voices not yet scanned.
- **Reset mid-scan:** the event is lost and all outputs return to reset values immediately (asynchronous).

## Configuration
- `VOICE_STEAL_EN` defined: the gated-voice fallback is active, so a note-on is never dropped.
- Undefined:
  - With no match, free or released candidate, the note-on is discarded.
  - `DROP` pulses 1 cycle in COMMIT; `GATE`, `TRIG` and ages are unchanged.
  - The gated-candidate tracking logic is not compiled.

## Structure
- **Package `synth_pkg`:**
  - `note_t` (7 bits), `vel_t` (7 bits)
  - `alloc_state_t` enum {IDLE, SCAN, COMMIT}
  - default `NUM_VOICES`
- **Sub-module `voice_age_tracker`:** holds the NUM_VOICES×AGE_W saturating age counters.
  - Input: commit strobe and target index.
  - Output: age bus read by the scan comparator.

## Test plan
- **Reset:** assert `RESET_N`=0 mid-SCAN → all outputs 0 asynchronously; release → `EVT_READY`=1 next cycle.
- **First note-on:** all `VOICE_IDLE`=1, note-on 60 vel 100 → after 9 cycles (N=8) `GATE`=0x01, `TRIG`=0x01 for one cycle, `VOICE_NOTE[0]`=60, `VOICE_VEL[0]`=100.
- **Note-off and velocity-0 note-on:**
  - note-off 60 → `GATE`=0x00 with no `TRIG`, `VOICE_NOTE[0]` stays 60;
  - repeat with note-on 60 vel 0 → same result.
- **Retrigger:** note-on 60 twice → second event retriggers voice 0 (`TRIG`=0x01), `GATE`=0x01, and voice 1 stays untouched.
- **Released preference:** gate notes 60..67 on voices 0..7, then note-off 63 with `VOICE_IDLE[3]`=0 → note-on 80 lands on voice 3, and voice 0 is not stolen.
- **Full pool:** notes 60..67 gated, then note-on 72:
  - with `VOICE_STEAL_EN`: voice 0 (oldest) gets 72 and `TRIG`=0x01;
  - without it: `DROP` pulses once and `GATE` stays 0xFF.
